// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions for the CPU trace buffer: opcodes, state/mode encodings
// and the trace entry width helper.
package cpu_dbg_pkg;

  localparam logic [4:0] OP_HALT = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_PC    = 2'b00,
    MODE_HALT  = 2'b01,
    MODE_MEMWR = 2'b10,
    MODE_IMM   = 2'b11
  } trace_mode_e;

  function automatic int entry_w(input int pc_w, input int ir_w, input int ad_w,
                                 input int data_w);
    return pc_w + ir_w + 1 + ad_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read (1 cycle).
// A same-address read and write in one cycle return the old content.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip CPU trace capture: circular sample buffer with mode-selected trigger and a
// post-trigger window, read back oldest-first with one cycle of latency.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int IR_W       = 16,
  parameter int AD_W       = 8,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          arm,
  input  logic [1:0]                                    mode,
  input  logic [PC_W-1:0]                               trig_pc,
  input  logic                                          smp_valid,
  input  logic [PC_W-1:0]                               smp_pc,
  input  logic [IR_W-1:0]                               smp_ir,
  input  logic                                          smp_we,
  input  logic [AD_W-1:0]                               smp_addr,
  input  logic [DATA_W-1:0]                             smp_data,
  input  logic                                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]                      rd_idx,
  output logic                                          rd_valid,
  output logic [entry_w(PC_W, IR_W, AD_W, DATA_W)-1:0]  rd_data,
  output logic [1:0]                                    state,
  output logic                                          done,
  output logic [$clog2(DEPTH):0]                        count,
  output logic [$clog2(DEPTH)-1:0]                      trig_idx
);

  localparam int ENTRY_W = entry_w(PC_W, IR_W, AD_W, DATA_W);
  localparam int IW      = $clog2(DEPTH);
  localparam logic [IW:0]   FULL   = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] POST_N = IW'(POST_DEPTH);

  trace_state_e  state_q, state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [IW-1:0] post_cnt_q, post_cnt_d;
  logic [IW-1:0] trig_idx_q, trig_idx_d;
  logic [IW:0]   trig_calc;
  logic          rd_valid_q, rd_hit_q;
  logic          wr_en, trig;
  logic [IW-1:0] base, rd_addr;
  logic [ENTRY_W-1:0] wr_data, ram_dout;

  always_comb begin
    trig = 1'b0;
    case (mode)
      MODE_PC:    trig = (smp_pc == trig_pc);
      MODE_HALT:  trig = (smp_ir[IR_W-1 -: 5] == OP_HALT);
      MODE_MEMWR: trig = smp_we;
      MODE_IMM:   trig = 1'b1;
      default:    trig = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_idx_d = trig_idx_q;
    trig_calc  = '0;
    wr_en      = 1'b0;
    // arm overrides everything, including a coincident trigger sample
    if (arm) begin
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      trig_idx_d = '0;
    end else if (smp_valid && (state_q == ST_ARMED || state_q == ST_POST)) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + IW'(1);
      if (count_q != FULL) count_d = count_q + (IW+1)'(1);
      if (state_q == ST_ARMED && trig) begin
        if (POST_DEPTH == 0) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_POST;
          post_cnt_d = POST_N;
        end
      end else if (state_q == ST_POST) begin
        post_cnt_d = post_cnt_q - IW'(1);
        if (post_cnt_q == IW'(1)) state_d = ST_DONE;
      end
      if (state_d == ST_DONE) begin
        trig_calc  = count_d - (IW+1)'(POST_DEPTH + 1);
        trig_idx_d = trig_calc[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_idx_q <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_idx_q <= trig_idx_d;
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en && ({1'b0, rd_idx} < count_q);
    end
  end

  // Once full, the oldest entry sits at the next write slot.
  assign base    = (count_q == FULL) ? wr_ptr_q : '0;
  assign rd_addr = base + rd_idx;
  assign wr_data = {smp_pc, smp_ir, smp_we, smp_addr, smp_data};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (ram_dout)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_hit_q ? ram_dout : '0;
  assign state    = state_q;
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;
  assign trig_idx = trig_idx_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed table rows, hand-written corner sequences and
// randomized traffic checked against a queue-based capture model.
module tb_cpu_trace_buffer;

  localparam int DEPTH   = 16;
  localparam int POST    = 8;
  localparam int ENTRY_W = 8 + 16 + 1 + 8 + 16;

  typedef logic [ENTRY_W-1:0] ent_t;

  logic        clk = 1'b0;
  logic        reset, arm, smp_valid, smp_we, rd_en;
  logic [1:0]  mode;
  logic [7:0]  trig_pc, smp_pc, smp_addr;
  logic [15:0] smp_ir, smp_data;
  logic [3:0]  rd_idx;
  logic        rd_valid, done;
  ent_t        rd_data;
  logic [1:0]  state;
  logic [4:0]  count;
  logic [3:0]  trig_idx;

  int errors = 0;
  int checks = 0;

  cpu_trace_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .mode      (mode),
    .trig_pc   (trig_pc),
    .smp_valid (smp_valid),
    .smp_pc    (smp_pc),
    .smp_ir    (smp_ir),
    .smp_we    (smp_we),
    .smp_addr  (smp_addr),
    .smp_data  (smp_data),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .state     (state),
    .done      (done),
    .count     (count),
    .trig_idx  (trig_idx)
  );

  always #5 clk = ~clk;

  // Capture model: the last DEPTH recorded samples, plus where the trigger landed.
  ent_t mlog[$];
  bit   m_active = 0;
  bit   m_fin    = 0;
  int   m_trig   = -1;
  int   m_left   = 0;

  function automatic bit trig_hit();
    case (mode)
      2'b00:   return smp_pc == trig_pc;
      2'b01:   return smp_ir[15:11] == 5'b00001;
      2'b10:   return smp_we;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    if (!reset || arm) begin
      m_active = reset;
      m_fin    = 0;
      m_trig   = -1;
      mlog.delete();
    end else if (m_active && !m_fin && smp_valid) begin
      mlog.push_back({smp_pc, smp_ir, smp_we, smp_addr, smp_data});
      if (mlog.size() > DEPTH) begin
        void'(mlog.pop_front());
        if (m_trig >= 0) m_trig--;
      end
      if (m_trig < 0) begin
        if (trig_hit()) begin
          m_trig = mlog.size() - 1;
          m_left = POST;
        end
      end else begin
        m_left--;
      end
      if (m_trig >= 0 && m_left == 0) m_fin = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: predict, advance, then compare every visible output.
  task automatic tick();
    ent_t exp_rd;
    bit   exp_rv;
    logic [1:0] exp_st;
    exp_rv = reset && rd_en;
    exp_rd = '0;
    if (exp_rv && int'(rd_idx) < mlog.size()) exp_rd = mlog[rd_idx];
    model_step();
    @(posedge clk);
    #1;
    exp_st = !m_active ? 2'b00 : m_fin ? 2'b11 : (m_trig >= 0) ? 2'b10 : 2'b01;
    chk("state", 64'(state), 64'(exp_st));
    chk("count", 64'(count), 64'(mlog.size()));
    chk("done", 64'(done), 64'(m_fin && m_active));
    if (m_fin && m_active) chk("trig_idx", 64'(trig_idx), 64'(m_trig));
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    if (exp_rv) chk("rd_data", 64'(rd_data), 64'(exp_rd));
  endtask

  function automatic ent_t mk_entry(input logic [7:0] p, input logic [7:0] hpc,
                                    input logic [7:0] wpc);
    logic [15:0] ir;
    ir = (p == hpc) ? 16'h0800 : {8'h10, p};
    return {p, ir, (p == wpc), p, {8'hA5, p}};
  endfunction

  task automatic drive(input logic [7:0] p, input logic [7:0] hpc, input logic [7:0] wpc);
    ent_t e;
    e = mk_entry(p, hpc, wpc);
    {smp_pc, smp_ir, smp_we, smp_addr, smp_data} = e;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] trig_pc;
    logic [7:0] halt_pc;
    logic [7:0] we_pc;
    int         exp_count;
    int         exp_trig;
    logic [3:0] rd0;
    logic [7:0] pc0;
    logic [3:0] rd1;
    logic [7:0] pc1;
    bit         zero1;
  } row_t;

  row_t rows[4];

  task automatic run_row(input row_t r, input int n);
    ent_t exp1;
    int   cyc;
    arm = 1'b1; mode = r.mode; trig_pc = r.trig_pc; smp_valid = 1'b0;
    tick();
    arm = 1'b0;
    cyc = 0;
    while (!done && cyc < 64) begin
      drive(8'(cyc), r.halt_pc, r.we_pc);
      smp_valid = 1'b1;
      tick();
      cyc++;
    end
    smp_valid = 1'b0;
    chk($sformatf("row%0d_done", n), 64'(done), 64'd1);
    chk($sformatf("row%0d_count", n), 64'(count), 64'(r.exp_count));
    chk($sformatf("row%0d_trig_idx", n), 64'(trig_idx), 64'(r.exp_trig));
    rd_en = 1'b1; rd_idx = r.rd0;
    tick();
    chk($sformatf("row%0d_rd0", n), 64'(rd_data), 64'(mk_entry(r.pc0, r.halt_pc, r.we_pc)));
    rd_idx = r.rd1;
    tick();
    exp1 = r.zero1 ? '0 : mk_entry(r.pc1, r.halt_pc, r.we_pc);
    chk($sformatf("row%0d_rd1", n), 64'(rd_data), 64'(exp1));
    rd_en = 1'b0;
  endtask

  initial begin
    rows[0] = '{2'b00, 8'h05, 8'hFF, 8'hFF, 14, 5, 4'd0, 8'h00, 4'd14, 8'h00, 1'b1};
    rows[1] = '{2'b00, 8'h20, 8'hFF, 8'hFF, 16, 7, 4'd0, 8'h19, 4'd15, 8'h28, 1'b0};
    rows[2] = '{2'b01, 8'hFF, 8'h03, 8'hFF, 12, 3, 4'd3, 8'h03, 4'd12, 8'h00, 1'b1};
    rows[3] = '{2'b10, 8'hFF, 8'hFF, 8'h03, 12, 3, 4'd3, 8'h03, 4'd11, 8'h0B, 1'b0};

    reset = 1'b0; arm = 1'b1; mode = 2'b00; trig_pc = '0; smp_valid = 1'b0;
    smp_pc = '0; smp_ir = '0; smp_we = 1'b0; smp_addr = '0; smp_data = '0;
    rd_en = 1'b0; rd_idx = '0;
    tick();
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b1; arm = 1'b0;
    tick();

    for (int r = 0; r < 4; r++) run_row(rows[r], r);

    // Immediate trigger with alternating valid: window must be contiguous.
    arm = 1'b1; mode = 2'b11; smp_valid = 1'b0;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive(8'(i), 8'hFF, 8'hFF);
      smp_valid = (i % 2 == 0);
      tick();
    end
    smp_valid = 1'b0;
    chk("imm_count", 64'(count), 64'(POST + 1));
    chk("imm_trig_idx", 64'(trig_idx), 64'd0);
    rd_en = 1'b1;
    for (int k = 0; k <= POST; k++) begin
      rd_idx = 4'(k);
      tick();
      chk($sformatf("imm_rd%0d", k), 64'(rd_data), 64'(mk_entry(8'(2 * k), 8'hFF, 8'hFF)));
    end
    rd_en = 1'b0;

    // arm coincident with a PC match wins; then reset during the post window.
    arm = 1'b1; mode = 2'b00; trig_pc = 8'h05;
    tick();
    arm = 1'b0; smp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(8'(i), 8'hFF, 8'hFF);
      tick();
    end
    arm = 1'b1;
    drive(8'h05, 8'hFF, 8'hFF);
    tick();
    chk("armwin_state", 64'(state), 64'd1);
    chk("armwin_count", 64'(count), 64'd0);
    arm = 1'b0;
    for (int i = 5; i < 8; i++) begin
      drive(8'(i), 8'hFF, 8'hFF);
      tick();
    end
    chk("post_state", 64'(state), 64'd2);
    reset = 1'b0;
    drive(8'h08, 8'hFF, 8'hFF);
    tick();
    chk("midpost_rst_state", 64'(state), 64'd0);
    chk("midpost_rst_count", 64'(count), 64'd0);
    chk("midpost_rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    for (int i = 9; i < 12; i++) begin
      drive(8'(i), 8'hFF, 8'hFF);
      tick();
    end
    chk("idle_nowrite_count", 64'(count), 64'd0);
    chk("idle_nowrite_state", 64'(state), 64'd0);
    smp_valid = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      arm   = ($urandom_range(0, 29) == 0);
      if (arm) begin
        mode    = 2'($urandom);
        trig_pc = 8'($urandom_range(0, 15));
      end
      smp_valid = ($urandom_range(0, 2) != 0);
      smp_pc    = 8'($urandom_range(0, 15));
      smp_ir    = 16'($urandom);
      if ($urandom_range(0, 9) == 0) smp_ir[15:11] = 5'b00001;
      else if (smp_ir[15:11] == 5'b00001) smp_ir[15] = 1'b1;
      smp_we   = ($urandom_range(0, 7) == 0);
      smp_addr = 8'($urandom);
      smp_data = 16'($urandom);
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_idx   = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
